cp0: RTL and testbench
======================

Name: cp0

Overview:
- Coprocessor 0 for the 5-stage MIPS core: holds SR, Cause, EPC and PRId.
- Detects interrupts and exceptions and drives Req and EPC into the PC register.
- Serves mfc0/mtc0 from the M stage.
- Sits at the M stage; its Req flushes the pipeline and redirects fetch to EXCPC, and its EPCOut supplies the eret target.

Parameters:
- PRID, 32'h2024_0C00, constant value returned by the PRId register (reg 15).
- HW_IRQS, 6, number of hardware interrupt lines (maps to bits 15:10).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- A1  in  5  mfc0 read register number.
- A2  in  5  mtc0 write register number.
- DIn  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable (M-stage mtc0, not flushed).
- VPC  in  32  PC of the M-stage victim instruction.
- BDIn  in  1  victim is in a branch delay slot.
- ExcCodeIn  in  5  M-stage exception code; 0 means none.
- HWInt  in  6  external interrupt lines, level-sensitive.
- EXLClr  in  1  eret in M stage; clears EXL.
- DOut  out  32  mfc0 read data.
- EPCOut  out  32  eret target to PC.
- Req  out  1  exception/interrupt request to PC and pipeline flush.

Behaviour:
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC(14): 32 bits.
  - PRId(15): PRID.
  - Any other A1 reads 0.
- Reset: async on reset_n low; SR, Cause, EPC all cleared to 0. Registers hold while reset_n is low.
- IntReq = IE & ~EXL & |(HWInt & IM).
- ExcReq = ~EXL & (ExcCodeIn != 0).
- Req = IntReq | ExcReq, combinational, zero-latency.
- Reset values of outputs:
  - Req = 0 while ExcCodeIn = 0.
  - DOut = 0 for reg 12/13/14.
  - EPCOut = 0.
- Interrupt has priority over a synchronous exception in the same cycle.
- On the posedge where Req = 1:
  - EXL <= 1.
  - ExcCode <= IntReq ? 0 : ExcCodeIn.
  - BD <= BDIn.
  - EPC <= BDIn ? VPC - 4 : VPC (32-bit wrap, no saturation).
  - Any simultaneous mtc0 write (WE) is discarded; any simultaneous EXLClr is ignored.
- IP[15:10] <= HWInt every cycle, independent of Req, EXL and WE; this is the only Cause write path besides exception entry.
- mtc0 with Req = 0:
  - A2 = 12 writes IM, EXL, IE from DIn[15:10], DIn[1], DIn[0].
  - A2 = 14 writes EPC <= DIn.
  - A2 = 13, A2 = 15 and other addresses are ignored; Cause and PRId are read-only to software.
- EXLClr with Req = 0: EXL <= 0 at the posedge. If mtc0 to SR happens in the same cycle, EXLClr wins for the EXL bit; IM and IE still take DIn.
- DOut: combinational read of the current register value. It does not forward a same-cycle mtc0.
- EPCOut forwards a same-cycle write: (WE & A2 = 14) ? DIn : EPC. This lets an eret immediately after an mtc0 EPC see the new value.
- While EXL = 1, no new Req is raised for either source; nested exceptions are masked.
- HWInt lines have no edge detection: a line held high re-triggers once eret clears EXL.

Decomposition:
- Shared header (HEAD): add to it, do not redefine.
  - ExcCode constants: EXC_INT 0, EXC_ADEL 4, EXC_ADES 5, EXC_SYSCALL 8, EXC_RI 10, EXC_OV 12.
  - CP0 register numbers: SR 12, CAUSE 13, EPC 14, PRID 15.
  - Existing TRUE and EXCPC constants.
- No sub-module is warranted: a single module with one register block and combinational request logic.

Test Plan:
- Reset then read: release reset_n, read A1 = 12/13/14/15 -> DOut = 0, 0, 0, 32'h2024_0C00; Req = 0.
- Interrupt entry: mtc0 SR <= 32'h0000_0401 (IM[10], IE), VPC = 32'h0000_3010, HWInt = 6'b000001 -> Req = 1 same cycle.
  - Next cycle: EPC = 32'h3010, ExcCode = 0, EXL = 1, Req = 0 with HWInt still high.
- Delay-slot exception: ExcCodeIn = 10, BDIn = 1, VPC = 32'h0000_3024 -> Req = 1.
  - Next cycle: EPC = 32'h3020, Cause[31] = 1, Cause[6:2] = 10.
- Priority and discard: IntReq and ExcCodeIn = 12 and WE (A2 = 14, DIn = 32'hDEAD_BEEF) in the same cycle -> ExcCode = 0, EPC = VPC, DEAD_BEEF not written.
- eret path: with EXL = 1, assert WE (A2 = 14, DIn = 32'h0000_3100) and EXLClr together -> EPCOut = 32'h3100 same cycle; next cycle EXL = 0.
  - With HWInt still high and IE/IM set, Req reasserts.
- Async reset mid-exception: drop reset_n between clock edges while EXL = 1 and EPC nonzero -> SR, Cause, EPC read 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor 0 block: exception codes, CP0
// register numbers and the exception vector.
package cp0_pkg;

  localparam logic        TRUE  = 1'b1;
  localparam logic [31:0] EXCPC = 32'h0000_4180;

  // Exception codes written into Cause.ExcCode
  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  // CP0 register numbers seen by mfc0/mtc0
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // Lowest bit of the IM / IP fields in SR and Cause
  localparam int IRQ_LSB = 10;

endpackage

// File: rtl/cp0.sv
// Coprocessor 0: SR, Cause, EPC and PRId, plus interrupt / exception
// request generation for the M stage.
//
// Req is a zero-latency combinational request: when it is high the PC
// register redirects to EXCPC and the pipeline is flushed, so at the same
// edge CP0 latches EPC/BD/ExcCode, sets EXL and drops any mtc0 or eret
// that was in flight.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID    = 32'h2024_0C00,
  parameter int          HW_IRQS = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [4:0]         A1,
  input  logic [4:0]         A2,
  input  logic [31:0]        DIn,
  input  logic               WE,
  input  logic [31:0]        VPC,
  input  logic               BDIn,
  input  logic [4:0]         ExcCodeIn,
  input  logic [HW_IRQS-1:0] HWInt,
  input  logic               EXLClr,
  output logic [31:0]        DOut,
  output logic [31:0]        EPCOut,
  output logic               Req
);

  logic [HW_IRQS-1:0] im_q, im_d;
  logic               exl_q, exl_d;
  logic               ie_q, ie_d;
  logic               bd_q, bd_d;
  logic [HW_IRQS-1:0] ip_q, ip_d;
  logic [4:0]         exc_code_q, exc_code_d;
  logic [31:0]        epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_rd;
  logic [31:0] cause_rd;

  // Request logic: EXL masks both sources, interrupts win over exceptions
  always_comb begin
    int_req = ie_q & ~exl_q & (|(HWInt & im_q));
    exc_req = ~exl_q & (ExcCodeIn != 5'd0);
    Req     = int_req | exc_req;
  end

  // Next-state: exception entry overrides software writes and eret
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    ip_d       = HWInt;
    if (Req) begin
      exl_d      = 1'b1;
      exc_code_d = int_req ? EXC_INT : ExcCodeIn;
      bd_d       = BDIn;
      epc_d      = BDIn ? (VPC - 32'd4) : VPC;
    end else begin
      if (WE && (A2 == CP0_SR)) begin
        im_d  = DIn[IRQ_LSB +: HW_IRQS];
        exl_d = DIn[1];
        ie_d  = DIn[0];
      end
      if (WE && (A2 == CP0_EPC)) begin
        epc_d = DIn;
      end
      // eret beats a same-cycle mtc0 for the EXL bit only
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  // Register block with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // Read views of SR and Cause; unimplemented bits read as zero
  always_comb begin
    sr_rd                        = 32'd0;
    sr_rd[IRQ_LSB +: HW_IRQS]    = im_q;
    sr_rd[1]                     = exl_q;
    sr_rd[0]                     = ie_q;
    cause_rd                     = 32'd0;
    cause_rd[31]                 = bd_q;
    cause_rd[IRQ_LSB +: HW_IRQS] = ip_q;
    cause_rd[6:2]                = exc_code_q;
  end

  // mfc0 read mux and eret target (forwards a same-cycle mtc0 EPC)
  always_comb begin
    case (A1)
      CP0_SR:    DOut = sr_rd;
      CP0_CAUSE: DOut = cause_rd;
      CP0_EPC:   DOut = epc_q;
      CP0_PRID:  DOut = PRID;
      default:   DOut = 32'd0;
    endcase
    EPCOut = (WE && (A2 == CP0_EPC)) ? DIn : epc_q;
  end

endmodule

// File: tb/tb_cp0.sv
// Bench for cp0: a directed vector table walking the main scenarios,
// a hand-written asynchronous reset sequence, then random cycles checked
// against a register-level model of CP0.
module tb_cp0;

  localparam logic [31:0] PRID_V = 32'h2024_0C00;

  logic        clk;
  logic        reset_n;
  logic [4:0]  A1, A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] DOut;
  logic [31:0] EPCOut;
  logic        Req;

  int checks   = 0;
  int failures = 0;

  cp0 #(.PRID(PRID_V), .HW_IRQS(6)) dut (
    .clk(clk), .reset_n(reset_n), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .DOut(DOut), .EPCOut(EPCOut), .Req(Req)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] vpc;
    logic        bdin;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        exlclr;
    logic        exp_req;
    logic [31:0] exp_dout;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] din, input logic we,
                              input logic [31:0] vpc, input logic bdin,
                              input logic [4:0] exc, input logic [5:0] hw,
                              input logic exlclr, input logic exp_req,
                              input logic [31:0] exp_dout, input logic [31:0] exp_epc);
    vec_t v;
    v.a1 = a1; v.a2 = a2; v.din = din; v.we = we; v.vpc = vpc; v.bdin = bdin;
    v.exc = exc; v.hw = hw; v.exlclr = exlclr; v.exp_req = exp_req;
    v.exp_dout = exp_dout; v.exp_epc = exp_epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    A1 = v.a1; A2 = v.a2; DIn = v.din; WE = v.we; VPC = v.vpc; BDIn = v.bdin;
    ExcCodeIn = v.exc; HWInt = v.hw; EXLClr = v.exlclr;
  endtask

  task automatic idle();
    A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; WE = 1'b0; VPC = 32'd0; BDIn = 1'b0;
    ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
  endtask

  // Register-level model: whole 32-bit register images updated by the
  // architectural rules for exception entry, mtc0, eret and IP sampling.
  logic [31:0] sr_m, cause_m, epc_m;

  function automatic logic model_int();
    return sr_m[0] && !sr_m[1] && ((HWInt & sr_m[15:10]) != 6'd0);
  endfunction

  function automatic logic model_req();
    return model_int() || (!sr_m[1] && ExcCodeIn != 5'd0);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return sr_m;
      5'd13:   return cause_m;
      5'd14:   return epc_m;
      5'd15:   return PRID_V;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_clock();
    logic        take, intr;
    logic [31:0] nsr, ncause, nepc;
    take = model_req();
    intr = model_int();
    nsr = sr_m; ncause = cause_m; nepc = epc_m;
    ncause[15:10] = HWInt;
    if (take) begin
      nsr[1]       = 1'b1;
      ncause[6:2]  = intr ? 5'd0 : ExcCodeIn;
      ncause[31]   = BDIn;
      nepc         = BDIn ? VPC - 32'd4 : VPC;
    end else begin
      if (WE && A2 == 5'd12) nsr = {16'd0, DIn[15:10], 8'd0, DIn[1], DIn[0]};
      if (WE && A2 == 5'd14) nepc = DIn;
      if (EXLClr) nsr[1] = 1'b0;
    end
    sr_m = nsr; cause_m = ncause; epc_m = nepc;
  endtask

  initial begin
    logic [4:0] exc_list[5];
    logic [4:0] a_list[6];

    //          a1     a2     din           we    vpc           bd    exc    hw          clr   req   dout          epcout
    vecs[0]  = mk(5'd12, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0);
    vecs[1]  = mk(5'd13, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0);
    vecs[2]  = mk(5'd14, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0);
    vecs[3]  = mk(5'd15, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, PRID_V,       32'h0);
    vecs[4]  = mk(5'd12, 5'd12, 32'h0000_0401,1'b1, 32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0);
    vecs[5]  = mk(5'd12, 5'd0,  32'h0,        1'b0, 32'h0000_3010,1'b0, 5'd0,  6'b000001, 1'b0, 1'b1, 32'h0000_0401,32'h0);
    vecs[6]  = mk(5'd14, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_3010,32'h0000_3010);
    vecs[7]  = mk(5'd13, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_0400,32'h0000_3010);
    vecs[8]  = mk(5'd12, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_0403,32'h0000_3010);
    vecs[9]  = mk(5'd14, 5'd14, 32'h0000_3100,1'b1, 32'h0,        1'b0, 5'd0,  6'b000001, 1'b1, 1'b0, 32'h0000_3010,32'h0000_3100);
    vecs[10] = mk(5'd12, 5'd0,  32'h0,        1'b0, 32'h0000_3040,1'b0, 5'd0,  6'b000001, 1'b0, 1'b1, 32'h0000_0401,32'h0000_3100);
    vecs[11] = mk(5'd14, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000000, 1'b1, 1'b0, 32'h0000_3040,32'h0000_3040);
    vecs[12] = mk(5'd13, 5'd0,  32'h0,        1'b0, 32'h0000_3024,1'b1, 5'd10, 6'b000000, 1'b0, 1'b1, 32'h0,        32'h0000_3040);
    vecs[13] = mk(5'd13, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h8000_0028,32'h0000_3020);
    vecs[14] = mk(5'd14, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_3020,32'h0000_3020);
    vecs[15] = mk(5'd13, 5'd0,  32'h0,        1'b0, 32'h0000_3030,1'b0, 5'd12, 6'b000000, 1'b0, 1'b0, 32'h8000_0028,32'h0000_3020);
    vecs[16] = mk(5'd12, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000000, 1'b1, 1'b0, 32'h0000_0403,32'h0000_3020);
    vecs[17] = mk(5'd14, 5'd14, 32'hDEAD_BEEF,1'b1, 32'h0000_3050,1'b0, 5'd12, 6'b000001, 1'b0, 1'b1, 32'h0000_3020,32'hDEAD_BEEF);
    vecs[18] = mk(5'd13, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_0400,32'h0000_3050);
    vecs[19] = mk(5'd14, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_3050,32'h0000_3050);
    vecs[20] = mk(5'd12, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000000, 1'b1, 1'b0, 32'h0000_0403,32'h0000_3050);
    vecs[21] = mk(5'd14, 5'd0,  32'h0,        1'b0, 32'h0,        1'b1, 5'd4,  6'b000000, 1'b0, 1'b1, 32'h0000_3050,32'h0000_3050);
    vecs[22] = mk(5'd14, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'hFFFF_FFFC,32'hFFFF_FFFC);
    vecs[23] = mk(5'd12, 5'd12, 32'h0000_0402,1'b1, 32'h0,        1'b0, 5'd0,  6'b000000, 1'b1, 1'b0, 32'h0000_0403,32'hFFFF_FFFC);
    vecs[24] = mk(5'd12, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_0400,32'hFFFF_FFFC);
    vecs[25] = mk(5'd13, 5'd13, 32'hFFFF_FFFF,1'b1, 32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h8000_0410,32'hFFFF_FFFC);
    vecs[26] = mk(5'd13, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h8000_0010,32'hFFFF_FFFC);

    // Reset
    idle();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Directed table: inputs applied at negedge, outputs sampled 1ns later
    for (int i = 0; i < 27; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d_req", i), {31'd0, Req}, {31'd0, vecs[i].exp_req});
      chk($sformatf("vec%0d_dout", i), DOut, vecs[i].exp_dout);
      chk($sformatf("vec%0d_epcout", i), EPCOut, vecs[i].exp_epc);
      @(negedge clk);
    end

    // Async reset mid-exception: enter a syscall, then clear between edges
    idle();
    ExcCodeIn = 5'd8; VPC = 32'h0000_1234;
    @(negedge clk);
    idle();
    A1 = 5'd14;
    #1 chk("pre_reset_epc", DOut, 32'h0000_1234);
    A1 = 5'd12;
    #1 chk("pre_reset_sr_exl", {31'd0, DOut[1]}, 32'd1);
    reset_n = 1'b0;
    #1 chk("async_sr", DOut, 32'd0);
    A1 = 5'd13;
    #1 chk("async_cause", DOut, 32'd0);
    A1 = 5'd14;
    #1 chk("async_epc", DOut, 32'd0);
    chk("async_epcout", EPCOut, 32'd0);
    chk("async_req", {31'd0, Req}, 32'd0);
    // Writes while held in reset must not land
    WE = 1'b1; A2 = 5'd14; DIn = 32'h5555_AAAA; HWInt = 6'h3F;
    @(negedge clk);
    WE = 1'b0;
    #1 chk("hold_epc", DOut, 32'd0);
    A1 = 5'd13;
    #1 chk("hold_cause", DOut, 32'd0);
    idle();
    reset_n = 1'b1;
    @(negedge clk);

    // Random cycles against the model, starting from the reset image
    sr_m = 32'd0; cause_m = 32'd0; epc_m = 32'd0;
    exc_list[0] = 5'd4; exc_list[1] = 5'd5; exc_list[2] = 5'd8;
    exc_list[3] = 5'd10; exc_list[4] = 5'd12;
    a_list[0] = 5'd12; a_list[1] = 5'd13; a_list[2] = 5'd14;
    a_list[3] = 5'd15; a_list[4] = 5'd0; a_list[5] = 5'd31;
    for (int n = 0; n < 400; n++) begin
      A1   = a_list[$urandom_range(0, 5)];
      A2   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : a_list[$urandom_range(0, 3)];
      WE   = ($urandom_range(0, 2) == 0);
      DIn  = ($urandom_range(0, 1) == 0) ? $urandom : ({$urandom} & 32'h0000_FC03);
      VPC  = {$urandom} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) VPC = 32'd0;
      BDIn = 1'($urandom);
      ExcCodeIn = ($urandom_range(0, 4) == 0) ? exc_list[$urandom_range(0, 4)] : 5'd0;
      HWInt  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      EXLClr = ($urandom_range(0, 5) == 0);
      #1;
      chk("rand_req", {31'd0, Req}, {31'd0, model_req()});
      chk("rand_dout", DOut, model_read(A1));
      chk("rand_epcout", EPCOut, (WE && A2 == 5'd14) ? DIn : epc_m);
      @(posedge clk);
      model_clock();
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
